// File: rtl/common.sv
// ---------------------------------------------------------------------------
// common
//   Shared types for the data-bus side of the core.
//     dbus_req_t   : request from a requester (valid + payload)
//     dbus_resp_t  : handshake/response returned by the data bus
//     arb_state_t  : state of the data-bus arbiter
//     ARB_MAX_PORTS: largest number of requesters the arbiter supports
//     wrap_inc     : index + 1, wrapping back to 0 at the port count
// ---------------------------------------------------------------------------
package common;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_t;

   localparam int ARB_MAX_PORTS = 8;

   // Next round-robin start position after port 'idx' has been served.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned nport);
      return (idx + 1 >= nport) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Picks the first asserted bit of a valid vector, searching upward from a
//   start index and wrapping around (round-robin), or from index 0 when the
//   round-robin mode is off (fixed priority).
//   Ports:
//     valid     in  NPORT : per-port request valid bits
//     start     in  IDW   : first index to consider in round-robin mode
//     rr_mode   in  1     : 1 = round-robin search, 0 = lowest index wins
//     winner    out IDW   : index of the selected port (0 when none valid)
//     any_valid out 1     : at least one port is requesting
// ---------------------------------------------------------------------------
module rr_picker #(
   parameter int NPORT = 2,
   parameter int IDW   = 1
) (
   input  logic [NPORT-1:0] valid,
   input  logic [IDW-1:0]   start,
   input  logic             rr_mode,
   output logic [IDW-1:0]   winner,
   output logic             any_valid
);

   logic [2*NPORT-1:0] doubled;
   logic [2*NPORT-1:0] masked;
   logic               found;
   int                 base;

   // The valid vector is laid out twice so a wrapping search becomes a plain
   // upward search: bits below the start index are masked off in the lower
   // copy, the upper copy supplies the wrapped-around ports, and the first
   // surviving bit (folded back modulo NPORT) is the winner.
   always_comb begin
      base      = rr_mode ? int'(start) : 0;
      doubled   = {valid, valid};
      masked    = '0;
      found     = 1'b0;
      winner    = '0;
      any_valid = |valid;
      for (int i = 0; i < 2*NPORT; i++) begin
         if (i >= base) begin
            masked[i] = doubled[i];
         end
      end
      for (int i = 0; i < 2*NPORT; i++) begin
         if (masked[i] && !found) begin
            found  = 1'b1;
            winner = IDW'((i >= NPORT) ? i - NPORT : i);
         end
      end
   end

endmodule

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
//   Merges NPORT requesters onto the single data bus. The grant is held for a
//   whole transaction (until data_ok, or until the owner drops valid), and the
//   bus response is routed only to the port that owns the bus.
//   Parameters:
//     NPORT : number of requesters (1..ARB_MAX_PORTS)
//     RR    : 0 = fixed priority (lowest index wins), 1 = round-robin
//   Ports:
//     clk      in  1           : clock
//     reset    in  1           : asynchronous active-low reset
//     req      in  [NPORT]     : per-port requests
//     resp     out [NPORT]     : per-port responses (zero for non-owners)
//     dreq     out dbus_req_t  : request presented to the data bus
//     dresp    in  dbus_resp_t : response from the data bus
//     grant_id out IDW         : port currently driving dreq (valid while busy)
//     busy     out 1           : transaction in flight or being issued now
// ---------------------------------------------------------------------------
module dbus_arbiter
   import common::*;
#(
   parameter int  NPORT = 2,
   parameter bit  RR    = 1'b0,
   localparam int IDW   = (NPORT > 1) ? $clog2(NPORT) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  dbus_req_t      req  [NPORT],
   output dbus_resp_t     resp [NPORT],
   output dbus_req_t      dreq,
   input  dbus_resp_t     dresp,
   output logic [IDW-1:0] grant_id,
   output logic           busy
);

   localparam int unsigned NPORT_U = NPORT;

   arb_state_t       state;
   arb_state_t       state_next;
   logic [IDW-1:0]   owner;
   logic [IDW-1:0]   owner_next;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   rr_ptr_next;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   sel;
   logic [NPORT-1:0] valid_vec;
   logic             any_valid;
   logic             active;

   // Gather the valid bits so the picker sees a flat vector.
   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < NPORT; i++) begin
         valid_vec[i] = req[i].valid;
      end
   end

   rr_picker #(
      .NPORT (NPORT),
      .IDW   (IDW)
   ) u_picker (
      .valid     (valid_vec),
      .start     (rr_ptr),
      .rr_mode   (RR),
      .winner    (winner),
      .any_valid (any_valid)
   );

   // State, owner and round-robin pointer registers. Reset abandons any
   // transaction in flight; the bus is expected to be reset alongside.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ARB_IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_next;
         owner  <= owner_next;
         rr_ptr <= rr_ptr_next;
      end
   end

   // Next-state logic. A winner that completes in its issue cycle never
   // enters BUSY. In BUSY, data_ok and an owner abort both end the
   // transaction the same way, so a simultaneous pair needs no special case.
   // The pointer moves only when a transaction ends.
   always_comb begin
      state_next  = state;
      owner_next  = owner;
      rr_ptr_next = rr_ptr;
      case (state)
         ARB_IDLE: begin
            if (any_valid) begin
               if (dresp.data_ok) begin
                  rr_ptr_next = IDW'(wrap_inc(32'(winner), NPORT_U));
               end else begin
                  owner_next = winner;
                  state_next = ARB_BUSY;
               end
            end
         end
         ARB_BUSY: begin
            if (dresp.data_ok || !req[owner].valid) begin
               state_next  = ARB_IDLE;
               rr_ptr_next = IDW'(wrap_inc(32'(owner), NPORT_U));
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Output mux. The selected port is the owner while BUSY, otherwise this
   // cycle's winner, so a fresh request reaches the bus with no added
   // latency. Reset is folded in combinationally so every output clears the
   // moment reset asserts, without waiting for a clock edge.
   always_comb begin
      active   = (state == ARB_BUSY) || any_valid;
      sel      = (state == ARB_BUSY) ? owner : winner;
      dreq     = '0;
      grant_id = '0;
      busy     = 1'b0;
      for (int j = 0; j < NPORT; j++) begin
         resp[j] = '0;
      end
      if (reset) begin
         grant_id = sel;
         busy     = active;
         if (active) begin
            dreq      = req[sel];
            resp[sel] = dresp;
         end
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dbus_arbiter
//   Two arbiters share clock and reset: u_fix (3 ports, fixed priority) and
//   u_rr (4 ports, round-robin). A behavioural model per instance predicts
//   every output on each falling edge; directed sequences pin the model with
//   literal expectations before a long randomized run.
// ---------------------------------------------------------------------------
module tb_dbus_arbiter;
   import common::*;

   logic       clk = 1'b0;
   logic       reset;

   dbus_req_t  req_f [3];
   dbus_resp_t resp_f [3];
   dbus_req_t  dreq_f;
   dbus_resp_t dresp_f;
   logic [1:0] gid_f;
   logic       busy_f;

   dbus_req_t  req_r [4];
   dbus_resp_t resp_r [4];
   dbus_req_t  dreq_r;
   dbus_resp_t dresp_r;
   logic [1:0] gid_r;
   logic       busy_r;

   int n_compared   = 0;
   int n_mismatched = 0;

   bit m_busy [2];
   int m_owner [2];
   int m_ptr [2];
   bit n_busy [2];
   int n_owner [2];
   int n_ptr [2];

   always #5 clk = ~clk;

   dbus_arbiter #(.NPORT(3), .RR(1'b0)) u_fix (
      .clk      (clk),
      .reset    (reset),
      .req      (req_f),
      .resp     (resp_f),
      .dreq     (dreq_f),
      .dresp    (dresp_f),
      .grant_id (gid_f),
      .busy     (busy_f)
   );

   dbus_arbiter #(.NPORT(4), .RR(1'b1)) u_rr (
      .clk      (clk),
      .reset    (reset),
      .req      (req_r),
      .resp     (resp_r),
      .dreq     (dreq_r),
      .dresp    (dresp_r),
      .grant_id (gid_r),
      .busy     (busy_r)
   );

   // Single comparison point: every check funnels through here.
   task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic dbus_req_t mk_req(input logic [31:0] addr);
      dbus_req_t r;
      r.valid  = 1'b1;
      r.addr   = addr;
      r.size   = 3'd2;
      r.strobe = 4'hf;
      r.data   = addr ^ 32'h5a5a_5a5a;
      return r;
   endfunction

   function automatic dbus_req_t rand_req();
      dbus_req_t r;
      r.valid  = 1'b1;
      r.addr   = $urandom;
      r.size   = 3'($urandom);
      r.strobe = 4'($urandom);
      r.data   = $urandom;
      return r;
   endfunction

   function automatic dbus_resp_t rand_resp();
      dbus_resp_t r;
      r.addr_ok = 1'($urandom);
      r.data_ok = ($urandom_range(0, 2) == 0);
      r.data    = $urandom;
      return r;
   endfunction

   // A requester keeps its request most of the time, occasionally aborts,
   // and idle ports raise new requests at random.
   function automatic dbus_req_t evolve(input dbus_req_t r);
      if (r.valid) begin
         if ($urandom_range(0, 7) == 0) return '0;
         return r;
      end
      if ($urandom_range(0, 2) == 0) return rand_req();
      return '0;
   endfunction

   function automatic dbus_req_t get_req(input int d, input int i);
      if (d == 0) return req_f[i];
      return req_r[i];
   endfunction

   function automatic dbus_resp_t get_resp(input int d, input int i);
      if (d == 0) return resp_f[i];
      return resp_r[i];
   endfunction

   task automatic clear_inputs();
      for (int i = 0; i < 3; i++) req_f[i] = '0;
      for (int i = 0; i < 4; i++) req_r[i] = '0;
      dresp_f = '0;
      dresp_r = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      next_cycle();
      reset = 1'b0;
      clear_inputs();
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < 3; i++) req_f[i] = evolve(req_f[i]);
      for (int i = 0; i < 4; i++) req_r[i] = evolve(req_r[i]);
      dresp_f = rand_resp();
      dresp_r = rand_resp();
      reset   = ($urandom_range(0, 199) != 0);
   endtask

   // Behavioural model of one arbiter: find the first valid port scanning
   // from the start position, decide who owns the bus, predict outputs and
   // work out the next bookkeeping (busy flag, owner, fairness pointer).
   task automatic eval_model(input int d);
      int         nn;
      int         start;
      int         w;
      int         idx;
      int         sel;
      bit         act;
      string      tag;
      dbus_req_t  r;
      dbus_req_t  ereq;
      dbus_resp_t dr;
      dbus_resp_t eresp;
      nn    = (d == 0) ? 3 : 4;
      tag   = (d == 0) ? "fix" : "rr";
      dr    = (d == 0) ? dresp_f : dresp_r;
      start = (d == 1) ? m_ptr[d] : 0;
      w     = -1;
      for (int k = 0; k < nn; k++) begin
         idx = (start + k) % nn;
         r   = get_req(d, idx);
         if (w < 0 && r.valid) w = idx;
      end
      act = reset && (m_busy[d] || w >= 0);
      sel = m_busy[d] ? m_owner[d] : ((w < 0) ? 0 : w);
      ereq = '0;
      if (act) ereq = get_req(d, sel);
      checkOutput({tag, "_dreq"}, 96'((d == 0) ? dreq_f : dreq_r), 96'(ereq));
      checkOutput({tag, "_busy"}, 96'((d == 0) ? busy_f : busy_r), 96'(act));
      if (act || !reset) begin
         checkOutput({tag, "_grant"}, 96'((d == 0) ? gid_f : gid_r), 96'(reset ? sel : 0));
      end
      for (int j = 0; j < nn; j++) begin
         eresp = '0;
         if (act && j == sel) eresp = dr;
         checkOutput($sformatf("%s_resp%0d", tag, j), 96'(get_resp(d, j)), 96'(eresp));
      end
      n_busy[d]  = m_busy[d];
      n_owner[d] = m_owner[d];
      n_ptr[d]   = m_ptr[d];
      if (m_busy[d]) begin
         r = get_req(d, m_owner[d]);
         if (dr.data_ok || !r.valid) begin
            n_busy[d] = 1'b0;
            n_ptr[d]  = (m_owner[d] + 1) % nn;
         end
      end else if (w >= 0) begin
         if (dr.data_ok) begin
            n_ptr[d] = (w + 1) % nn;
         end else begin
            n_busy[d]  = 1'b1;
            n_owner[d] = w;
         end
      end
   endtask

   // Compare process: outputs are settled mid-cycle, inputs only change just
   // after the rising edge or while reset is asserted.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) eval_model(d);
   end

   // Model bookkeeping advances on the clock and clears with reset.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            m_busy[d]  <= 1'b0;
            m_owner[d] <= 0;
            m_ptr[d]   <= 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_busy[d]  <= n_busy[d];
            m_owner[d] <= n_owner[d];
            m_ptr[d]   <= n_ptr[d];
         end
      end
   end

   initial begin
      reset = 1'b0;
      clear_inputs();

      // Held in reset with random traffic: nothing may leak out.
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 3; i++) req_f[i] = rand_req();
         for (int i = 0; i < 4; i++) req_r[i] = rand_req();
         dresp_f = rand_resp();
         dresp_r = rand_resp();
         dresp_r.data_ok = 1'b1;
         @(negedge clk);
         checkOutput("rst_dreq_valid", 96'(dreq_r.valid), 96'(0));
         checkOutput("rst_busy", 96'(busy_r), 96'(0));
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst_resp%0d", i), 96'(resp_r[i]), 96'(0));
         end
         next_cycle();
      end

      // Release: port 1's request reaches the bus in the same cycle.
      clear_inputs();
      req_r[1] = mk_req(32'h8000_0010);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("release_addr", 96'(dreq_r.addr), 96'(32'h8000_0010));
      checkOutput("release_valid", 96'(dreq_r.valid), 96'(1));
      checkOutput("release_grant", 96'(gid_r), 96'(1));

      // Asynchronous reset while BUSY clears outputs between clock edges.
      next_cycle();
      dresp_r.data_ok = 1'b1;
      dresp_r.data    = 32'h1234_5678;
      #1;
      checkOutput("pre_rst_busy", 96'(busy_r), 96'(1));
      checkOutput("pre_rst_resp1", 96'(resp_r[1].data), 96'(32'h1234_5678));
      #1;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_busy", 96'(busy_r), 96'(0));
      checkOutput("async_rst_dreq", 96'(dreq_r), 96'(0));
      checkOutput("async_rst_resp1", 96'(resp_r[1]), 96'(0));
      checkOutput("async_rst_grant", 96'(gid_r), 96'(0));
      next_cycle();
      clear_inputs();
      next_cycle();
      reset = 1'b1;

      // Fixed priority: all three valid, served 0,1,2 with data_ok 3 cycles in.
      for (int i = 0; i < 3; i++) req_f[i] = mk_req(32'h0000_1000 + 32'(i * 16));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("fix_grant%0d", k), 96'(gid_f), 96'(k));
         checkOutput($sformatf("fix_addr%0d", k), 96'(dreq_f.addr), 96'(32'h0000_1000 + 32'(k * 16)));
         next_cycle();
         next_cycle();
         next_cycle();
         dresp_f.data_ok = 1'b1;
         dresp_f.data    = 32'hDEAD_0000 + 32'(k);
         @(negedge clk);
         checkOutput($sformatf("fix_resp_data%0d", k), 96'(resp_f[k].data), 96'(32'hDEAD_0000 + 32'(k)));
         checkOutput($sformatf("fix_resp_ok%0d", k), 96'(resp_f[k].data_ok), 96'(1));
         next_cycle();
         dresp_f  = '0;
         req_f[k] = '0;
      end

      // Round-robin fairness with every port always requesting.
      reset_pulse();
      for (int i = 0; i < 4; i++) req_r[i] = mk_req(32'h2000_0000 + 32'(i * 4));
      dresp_r.data_ok = 1'b1;
      dresp_r.data    = 32'hC0DE_0000;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("rr_grant_seq%0d", k), 96'(gid_r), 96'(k % 4));
         next_cycle();
      end
      clear_inputs();

      // Lock: port 1 holds the bus for 5 cycles despite port 0 arriving.
      reset_pulse();
      req_r[1] = mk_req(32'hA000_0100);
      for (int c = 0; c < 7; c++) begin
         if (c == 2) req_r[0] = mk_req(32'hB000_0000);
         if (c == 5) begin
            dresp_r.data_ok = 1'b1;
            dresp_r.data    = 32'h5555_AAAA;
         end
         if (c == 6) begin
            req_r[1] = '0;
            dresp_r  = '0;
         end
         @(negedge clk);
         if (c < 6) begin
            checkOutput($sformatf("lock_addr%0d", c), 96'(dreq_r.addr), 96'(32'hA000_0100));
            checkOutput($sformatf("lock_grant%0d", c), 96'(gid_r), 96'(1));
            checkOutput($sformatf("lock_resp0_%0d", c), 96'(resp_r[0].data_ok), 96'(0));
         end else begin
            checkOutput("lock_next_grant", 96'(gid_r), 96'(0));
            checkOutput("lock_next_addr", 96'(dreq_r.addr), 96'(32'hB000_0000));
         end
         if (c == 5) checkOutput("lock_resp1_data", 96'(resp_r[1].data), 96'(32'h5555_AAAA));
         next_cycle();
      end
      clear_inputs();

      // Abort: owner port 2 drops valid, pending port 0 takes over.
      reset_pulse();
      req_r[2] = mk_req(32'hC000_0008);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) req_r[0] = mk_req(32'hD000_0000);
         if (c == 2) req_r[2] = '0;
         @(negedge clk);
         if (c == 2) checkOutput("abort_owner", 96'(gid_r), 96'(2));
         if (c == 3) begin
            checkOutput("abort_state", 96'(u_rr.state), 96'(ARB_IDLE));
            checkOutput("abort_rr_ptr", 96'(u_rr.rr_ptr), 96'(3));
            checkOutput("abort_grant", 96'(gid_r), 96'(0));
            checkOutput("abort_addr", 96'(dreq_r.addr), 96'(32'hD000_0000));
         end
         next_cycle();
      end
      clear_inputs();

      // Randomized traffic on both instances, checked by the model.
      reset_pulse();
      for (int c = 0; c < 3000; c++) begin
         applyStimulus();
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
